// File: rtl/timer_clint_pkg.sv
// Shared constants, types and helpers for the machine timer / software-interrupt unit.
package timer_clint_pkg;

    localparam logic [31:0] CLINT_BASE            = 32'h0200_0000;
    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF    = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_OFF       = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } resp_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_t;

    // Byte offset inside the window; the two low address bits are ignored.
    function automatic reg_sel_t reg_decode(input logic [15:0] offset);
        logic [15:0] word_off;
        word_off = {offset[15:2], 2'b00};
        case (word_off)
            CLINT_MSIP_OFF:        return REG_MSIP;
            CLINT_MTIMECMP_OFF:    return REG_CMP_LO;
            CLINT_MTIMECMP_HI_OFF: return REG_CMP_HI;
            CLINT_MTIME_OFF:       return REG_MTIME_LO;
            CLINT_MTIME_HI_OFF:    return REG_MTIME_HI;
            default:               return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_clint_mtime.sv
// Prescaler plus free-running 64-bit mtime counter with byte-masked lo/hi write ports.
module timer_clint_mtime
    import timer_clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [63:0] mtime,
    output logic        tick
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt;

    assign tick = !halt && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            mtime   <= '0;
        end else begin
            // Halt freezes the count in place rather than clearing it.
            if (!halt) begin
                pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 16'd1;
            end
            // A software write to either word wins over the tick increment.
            if (lo_we || hi_we) begin
                if (lo_we) mtime[31:0]  <= byte_merge(mtime[31:0],  wdata, wmask);
                if (hi_we) mtime[63:32] <= byte_merge(mtime[63:32], wdata, wmask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/timer_clint.sv
// Memory-mapped machine timer and software interrupt: dbus decode, response FSM,
// mtimecmp, msip and the registered timer compare.
module timer_clint
    import timer_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_data,
    input  logic [3:0]  I_mask,
    input  logic        I_dbg_halt,
    output logic [31:0] O_data,
    output logic        O_ready,
    output logic        O_timer_int,
    output logic        O_soft_int
);

    resp_state_t state;
    reg_sel_t    sel;
    logic        accept;
    logic        wr_acc;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        mtime_tick;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign sel    = reg_decode(I_addr[15:0]);
    assign accept = (state == ST_IDLE) && I_req && (I_addr[31:16] == BASE_ADDR[31:16]);
    assign wr_acc = accept && I_we;

    assign unused_bits = ^{I_addr[1:0], mtime_tick};

    timer_clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk   (clk),
        .rst   (rst),
        .halt  (I_dbg_halt),
        .lo_we (wr_acc && (sel == REG_MTIME_LO)),
        .hi_we (wr_acc && (sel == REG_MTIME_HI)),
        .wdata (I_data),
        .wmask (I_mask),
        .mtime (mtime),
        .tick  (mtime_tick)
    );

    always_comb begin
        rd_word = '0;
        case (sel)
            REG_MSIP:     rd_word = {31'd0, msip};
            REG_CMP_LO:   rd_word = mtimecmp[31:0];
            REG_CMP_HI:   rd_word = mtimecmp[63:32];
            REG_MTIME_LO: rd_word = mtime[31:0];
            REG_MTIME_HI: rd_word = mtime[63:32];
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            O_ready     <= 1'b0;
            O_data      <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            O_timer_int <= 1'b0;
        end else begin
            O_timer_int <= (mtime >= mtimecmp);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_RESP;
                        O_ready <= 1'b1;
                        O_data  <= rd_word;
                        if (I_we) begin
                            case (sel)
                                REG_MSIP:   if (I_mask[0]) msip <= I_data[0];
                                REG_CMP_LO: mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0],  I_data, I_mask);
                                REG_CMP_HI: mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], I_data, I_mask);
                                default: ;
                            endcase
                        end
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    O_ready <= 1'b0;
                    O_data  <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    O_ready <= 1'b0;
                    O_data  <= '0;
                end
            endcase
        end
    end

    assign O_soft_int = msip;

endmodule

// File: tb/tb_timer_clint.sv
// Directed bench for timer_clint (PRESCALE=4); edge numbers count rising edges after reset release.
module tb_timer_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req;
    logic        I_we;
    logic [31:0] I_addr;
    logic [31:0] I_data;
    logic [3:0]  I_mask;
    logic        I_dbg_halt;
    logic [31:0] O_data;
    logic        O_ready;
    logic        O_timer_int;
    logic        O_soft_int;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    logic        rsp_ready, rsp_tint, rsp_soft, idle_ready;
    logic [31:0] rsp_data, idle_data;

    timer_clint #(
        .BASE_ADDR (32'h0200_0000),
        .PRESCALE  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .I_req       (I_req),
        .I_we        (I_we),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .I_mask      (I_mask),
        .I_dbg_halt  (I_dbg_halt),
        .O_data      (O_data),
        .O_ready     (O_ready),
        .O_timer_int (O_timer_int),
        .O_soft_int  (O_soft_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at edge n + 1 time unit.
    task automatic go_to(input int unsigned n);
        if (cyc > n) check("schedule", 64'(cyc), 64'(n));
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request accepted at the next edge; returns one time unit after the edge that follows.
    task automatic bus_cycle(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] mask);
        I_req  = 1'b1;
        I_we   = we;
        I_addr = addr;
        I_data = data;
        I_mask = mask;
        @(posedge clk);
        #1;
        I_req = 1'b0;
        I_we  = 1'b0;
        rsp_ready = O_ready;
        rsp_data  = O_data;
        rsp_tint  = O_timer_int;
        rsp_soft  = O_soft_int;
        @(posedge clk);
        #1;
        idle_ready = O_ready;
        idle_data  = O_data;
    endtask

    task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        bus_cycle(1'b0, addr, 32'h0, 4'h0);
        check({tag, ".rdy"}, 64'(rsp_ready), 64'd1);
        check(tag, 64'(rsp_data), 64'(exp));
        check({tag, ".drop"}, {31'd0, idle_ready, idle_data}, 64'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input string tag);
        bus_cycle(1'b1, addr, data, mask);
        check({tag, ".rdy"}, 64'(rsp_ready), 64'd1);
        check({tag, ".drop"}, 64'(idle_ready), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned pulses;
        rst = 1'b0; I_req = 1'b0; I_we = 1'b0; I_addr = '0; I_data = '0; I_mask = '0;
        I_dbg_halt = 1'b0;
        #2;
        check("rst.ready", 64'(O_ready), 64'd0);
        check("rst.data",  64'(O_data),  64'd0);
        check("rst.tint",  64'(O_timer_int), 64'd0);
        check("rst.soft",  64'(O_soft_int),  64'd0);
        #14 rst = 1'b1;

        // Edges 1 and 3.
        rd(32'h0200_BFFC, "mtime_hi.reset", 32'h0);
        rd(32'h0200_4004, "cmp_hi.reset",   32'hFFFF_FFFF);
        check("tint.reset", 64'(O_timer_int), 64'd0);

        // Ticks land on edges 4,8,...,40: ten ticks before edge 41.
        go_to(40);
        rd(32'h0200_BFF8, "mtime_lo.free", 32'd10);

        // Halt edges 43..62; prescaler resumes at 2, ticks at 64 and 68.
        I_dbg_halt = 1'b1;
        go_to(62);
        I_dbg_halt = 1'b0;
        go_to(69);
        rd(32'h0200_BFF8, "mtime_lo.halt", 32'd12);

        // Prescaler parked at 3 while halted; first unhalted edge 77 ticks.
        I_dbg_halt = 1'b1;
        go_to(72);
        wr(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, "wr_mtime_lo");
        wr(32'h0200_BFFC, 32'h0, 4'hF, "wr_mtime_hi");
        I_dbg_halt = 1'b0;
        go_to(77);
        rd(32'h0200_BFF8, "carry.lo", 32'h0);
        rd(32'h0200_BFFC, "carry.hi", 32'h1);

        // Edge 85 is a tick edge; the write suppresses that increment.
        go_to(84);
        wr(32'h0200_BFF8, 32'h55, 4'hF, "wr_on_tick");
        rd(32'h0200_BFF8, "tick_write.lo", 32'h55);

        // Compare setup while halted, prescaler parked at 3.
        I_dbg_halt = 1'b1;
        go_to(89);
        wr(32'h0200_BFFC, 32'h0,   4'hF, "cmp.mt_hi");
        wr(32'h0200_BFF8, 32'd90,  4'hF, "cmp.mt_lo");
        wr(32'h0200_4000, 32'd100, 4'hF, "cmp.lo");
        wr(32'h0200_4004, 32'h0,   4'hF, "cmp.hi");
        check("tint.below", 64'(O_timer_int), 64'd0);
        I_dbg_halt = 1'b0;
        // Ticks at 98 + 4j give mtime 91 + j: mtime reaches 100 at edge 134.
        go_to(134);
        check("tint.at_match", 64'(O_timer_int), 64'd0);
        go_to(135);
        check("tint.rise", 64'(O_timer_int), 64'd1);
        go_to(136);
        wr(32'h0200_4004, 32'hFFFF_FFFF, 4'hF, "cmp.hi_max");
        check("tint.hold_write_edge", 64'(rsp_tint), 64'd1);
        check("tint.fall", 64'(O_timer_int), 64'd0);

        wr(32'h0200_4000, 32'hFFFF_FFFF, 4'hF, "cmp.lo_max");
        wr(32'h0200_4000, 32'hAABB_CCDD, 4'b0010, "cmp.masked");
        rd(32'h0200_4000, "cmp.masked_rd", 32'hFFFF_CCFF);

        wr(32'h0200_0000, 32'h3, 4'hF, "msip.set");
        check("soft.set", 64'(rsp_soft), 64'd1);
        rd(32'h0200_0000, "msip.rd", 32'h1);
        rd(32'h0200_1000, "unmapped.rd", 32'h0);
        wr(32'h0200_0000, 32'h0, 4'h0, "msip.nomask");
        rd(32'h0200_0000, "msip.kept", 32'h1);
        check("soft.kept", 64'(O_soft_int), 64'd1);

        // Held request over edges 155..160: accepts at 155, 157, 159.
        go_to(154);
        pulses = 0;
        I_req = 1'b1; I_we = 1'b0; I_addr = 32'h0200_0000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("burst.ready%0d", i), 64'(O_ready), 64'((i % 2) == 0));
            if (O_ready) pulses++;
        end
        I_req = 1'b0;
        check("burst.pulses", 64'(pulses), 64'd3);

        I_req = 1'b1; I_we = 1'b0; I_addr = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("miss.read%0d", i), 64'(O_ready), 64'd0);
        end
        I_we = 1'b1; I_addr = 32'h0300_4000; I_data = 32'h0; I_mask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("miss.write%0d", i), 64'(O_ready), 64'd0);
        end
        I_req = 1'b0; I_we = 1'b0;
        rd(32'h0200_4000, "miss.cmp_kept", 32'hFFFF_CCFF);

        // Reset while the response is on the bus.
        go_to(166);
        I_req = 1'b1; I_we = 1'b0; I_addr = 32'h0200_4004;
        @(posedge clk);
        #1;
        I_req = 1'b0;
        check("midrst.ready_before", 64'(O_ready), 64'd1);
        check("midrst.data_before",  64'(O_data),  64'hFFFF_FFFF);
        rst = 1'b0;
        #1;
        check("midrst.ready", 64'(O_ready), 64'd0);
        check("midrst.data",  64'(O_data),  64'd0);
        check("midrst.tint",  64'(O_timer_int), 64'd0);
        check("midrst.soft",  64'(O_soft_int),  64'd0);
        #1 rst = 1'b1;
        rd(32'h0200_BFF8, "post_rst.mtime_lo", 32'h0);
        rd(32'h0200_BFFC, "post_rst.mtime_hi", 32'h0);
        rd(32'h0200_4000, "post_rst.cmp_lo",   32'hFFFF_FFFF);
        rd(32'h0200_0000, "post_rst.msip",     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
